// File: rtl/dac_write_arbiter.sv
// dac_write_arbiter: shares one dual-channel DAC bus between the PS command
// path and the servo datapath. Each accepted request drives a fixed
// setup -> strobe -> hold write cycle on the pins. When the HOLD state ends,
// the written code is copied into a per-channel shadow register for readback.
// Configuration macro: DAC_ARB_ROUND_ROBIN_EN. When it is defined, ties are
// resolved round-robin. When it is undefined, the servo wins every tie.
module dac_write_arbiter #(
    parameter int unsigned                DAC_DATA_WIDTH = 14,
    parameter logic [DAC_DATA_WIDTH-1:0]  MIDSCALE       = 14'h2000
) (
    input  logic                      clk,
    input  logic                      rst_ni,
    input  logic                      ps_valid_i,
    input  logic                      ps_sel_i,
    input  logic [DAC_DATA_WIDTH-1:0] ps_data_i,
    output logic                      ps_ready_o,
    input  logic                      lp_valid_i,
    input  logic                      lp_sel_i,
    input  logic [DAC_DATA_WIDTH-1:0] lp_data_i,
    output logic                      lp_ready_o,
    output logic [DAC_DATA_WIDTH-1:0] dac_dat_o,
    output logic                      dac_sel_o,
    output logic                      dac_wrt_o,
    output logic [DAC_DATA_WIDTH-1:0] shadow_a_o,
    output logic [DAC_DATA_WIDTH-1:0] shadow_b_o,
    output logic                      busy_o,
    output logic                      grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [DAC_DATA_WIDTH-1:0] dat_q, dat_d;
    logic [DAC_DATA_WIDTH-1:0] shadow_a_q, shadow_a_d;
    logic [DAC_DATA_WIDTH-1:0] shadow_b_q, shadow_b_d;
    logic                      sel_q, sel_d;
    logic                      wrt_q, wrt_d;
    logic                      grant_q, grant_d;
    logic                      busy_q, busy_d;
    logic                      ps_win_s, lp_win_s;
    logic                      idle_s;

    assign idle_s = (state_q == ST_IDLE);

    // Combinational arbitration between the two valids.
    // grant_q == 1 means the servo owned the last write, so PS wins the next tie.
    always_comb begin
        ps_win_s = 1'b0;
        lp_win_s = 1'b0;
        if (ps_valid_i && lp_valid_i) begin
`ifdef DAC_ARB_ROUND_ROBIN_EN
            if (grant_q) begin
                ps_win_s = 1'b1;
            end else begin
                lp_win_s = 1'b1;
            end
`else
            lp_win_s = 1'b1;
`endif
        end else if (ps_valid_i) begin
            ps_win_s = 1'b1;
        end else if (lp_valid_i) begin
            lp_win_s = 1'b1;
        end else begin
            ps_win_s = 1'b0;
            lp_win_s = 1'b0;
        end
    end

    // A request is accepted only in IDLE, in the same cycle it wins arbitration.
    assign ps_ready_o = idle_s & ps_win_s;
    assign lp_ready_o = idle_s & lp_win_s;

    // Next-state logic for the fixed write sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ps_win_s || lp_win_s) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values: latch the winner, drive the strobe, update the shadow.
    always_comb begin
        dat_d      = dat_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        case (state_q)
            ST_IDLE: begin
                if (ps_win_s) begin
                    dat_d   = ps_data_i;
                    sel_d   = ps_sel_i;
                    grant_d = 1'b0;
                end else if (lp_win_s) begin
                    dat_d   = lp_data_i;
                    sel_d   = lp_sel_i;
                    grant_d = 1'b1;
                end else begin
                    dat_d   = dat_q;
                end
            end
            ST_HOLD: begin
                if (sel_q) begin
                    shadow_b_d = dat_q;
                end else begin
                    shadow_a_d = dat_q;
                end
            end
            default: begin
                dat_d = dat_q;
            end
        endcase
        wrt_d  = (state_d == ST_STROBE);
        busy_d = (state_d != ST_IDLE);
    end

    // State register. An asynchronous reset drops any write that is in flight.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered pins, strobe, shadows and status outputs.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_q      <= MIDSCALE;
            sel_q      <= 1'b0;
            wrt_q      <= 1'b0;
            grant_q    <= 1'b1;
            busy_q     <= 1'b0;
            shadow_a_q <= MIDSCALE;
            shadow_b_q <= MIDSCALE;
        end else begin
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            wrt_q      <= wrt_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
        end
    end

    assign dac_dat_o  = dat_q;
    assign dac_sel_o  = sel_q;
    assign dac_wrt_o  = wrt_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign shadow_a_o = shadow_a_q;
    assign shadow_b_o = shadow_b_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Bench for dac_write_arbiter. Randomised requesters are checked against a
// transaction-level model. The model keeps a busy count, the last owner, the
// pins and the shadows. Expected writes go into a queue, and a monitor checks
// each strobe against it. The bench follows the DUT's arbitration mode through
// DAC_ARB_ROUND_ROBIN_EN.
module tb_dac_write_arbiter;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         ps_valid_i = 1'b0, ps_sel_i = 1'b0;
    logic [W-1:0] ps_data_i = '0;
    logic         lp_valid_i = 1'b0, lp_sel_i = 1'b0;
    logic [W-1:0] lp_data_i = '0;
    logic         ps_ready_o, lp_ready_o;
    logic [W-1:0] dac_dat_o, shadow_a_o, shadow_b_o;
    logic         dac_sel_o, dac_wrt_o, busy_o, grant_o;

    dac_write_arbiter dut (
        .clk(clk), .rst_ni(rst_ni),
        .ps_valid_i(ps_valid_i), .ps_sel_i(ps_sel_i), .ps_data_i(ps_data_i), .ps_ready_o(ps_ready_o),
        .lp_valid_i(lp_valid_i), .lp_sel_i(lp_sel_i), .lp_data_i(lp_data_i), .lp_ready_o(lp_ready_o),
        .dac_dat_o(dac_dat_o), .dac_sel_o(dac_sel_o), .dac_wrt_o(dac_wrt_o),
        .shadow_a_o(shadow_a_o), .shadow_b_o(shadow_b_o),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int strobes = 0;

    typedef struct packed { logic sel; logic [W-1:0] dat; logic grant; } wr_t;
    wr_t exp_q[$];

    // Model state.
    int           busy_cnt = 0;   // cycles left in the current write sequence
    logic         m_grant = 1'b1;
    logic         m_sel = 1'b0;
    logic [W-1:0] m_dat = 14'h2000;
    logic [W-1:0] m_sh_a = 14'h2000, m_sh_b = 14'h2000;

    // Requester state.
    logic         ps_pend = 1'b0, lp_pend = 1'b0;
    logic         ps_s = 1'b0, lp_s = 1'b0;
    logic [W-1:0] ps_d = '0, lp_d = '0;
    int           ps_rate = 0, lp_rate = 0;
    int           ps_accepts = 0, lp_accepts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_ni && dac_wrt_o) begin
            strobes++;
            if (exp_q.size() == 0) begin
                check("strobe_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("strobe_dat", {18'd0, dac_dat_o}, {18'd0, e.dat});
                check("strobe_sel", {31'd0, dac_sel_o}, {31'd0, e.sel});
                check("strobe_grant", {31'd0, grant_o}, {31'd0, e.grant});
            end
        end
    end

    // One clock of stimulus, model arbitration, checks, and model update.
    task automatic step();
        logic ps_acc, lp_acc;
        if (!ps_pend && ($urandom_range(99) < ps_rate)) begin
            ps_pend = 1'b1; ps_s = 1'($urandom); ps_d = W'($urandom);
        end
        if (!lp_pend && ($urandom_range(99) < lp_rate)) begin
            lp_pend = 1'b1; lp_s = 1'($urandom); lp_d = W'($urandom);
        end
        ps_valid_i = ps_pend; ps_sel_i = ps_s; ps_data_i = ps_d;
        lp_valid_i = lp_pend; lp_sel_i = lp_s; lp_data_i = lp_d;
        ps_acc = 1'b0; lp_acc = 1'b0;
        if (busy_cnt == 0) begin
            if (ps_pend && lp_pend) begin
`ifdef DAC_ARB_ROUND_ROBIN_EN
                if (m_grant) ps_acc = 1'b1; else lp_acc = 1'b1;
`else
                lp_acc = 1'b1;
`endif
            end else if (ps_pend) ps_acc = 1'b1;
            else if (lp_pend) lp_acc = 1'b1;
        end
        @(negedge clk);
        check("ps_ready", {31'd0, ps_ready_o}, {31'd0, ps_acc});
        check("lp_ready", {31'd0, lp_ready_o}, {31'd0, lp_acc});
        check("busy", {31'd0, busy_o}, {31'd0, (busy_cnt != 0)});
        check("wrt", {31'd0, dac_wrt_o}, {31'd0, (busy_cnt == 2)});
        check("pin_dat", {18'd0, dac_dat_o}, {18'd0, m_dat});
        check("pin_sel", {31'd0, dac_sel_o}, {31'd0, m_sel});
        check("grant", {31'd0, grant_o}, {31'd0, m_grant});
        check("shadow_a", {18'd0, shadow_a_o}, {18'd0, m_sh_a});
        check("shadow_b", {18'd0, shadow_b_o}, {18'd0, m_sh_b});
        @(posedge clk);
        if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                if (m_sel) m_sh_b = m_dat; else m_sh_a = m_dat;
            end
        end else if (ps_acc || lp_acc) begin
            busy_cnt = 3;
            m_grant  = lp_acc;
            m_sel    = ps_acc ? ps_s : lp_s;
            m_dat    = ps_acc ? ps_d : lp_d;
            exp_q.push_back('{sel: m_sel, dat: m_dat, grant: m_grant});
            if (ps_acc) begin ps_pend = 1'b0; ps_accepts++; end
            else begin lp_pend = 1'b0; lp_accepts++; end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_reset();
        busy_cnt = 0; m_grant = 1'b1; m_sel = 1'b0; m_dat = 14'h2000;
        m_sh_a = 14'h2000; m_sh_b = 14'h2000;
        exp_q.delete();
        ps_pend = 1'b0; lp_pend = 1'b0; ps_rate = 0; lp_rate = 0;
        ps_valid_i = 1'b0; lp_valid_i = 1'b0;
    endtask

    initial begin
        int guard;
        int lp_before;
        // Reset state.
        #22;
        check("rst_dat", {18'd0, dac_dat_o}, 32'h2000);
        check("rst_sel", {31'd0, dac_sel_o}, 32'd0);
        check("rst_wrt", {31'd0, dac_wrt_o}, 32'd0);
        check("rst_grant", {31'd0, grant_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_sha", {18'd0, shadow_a_o}, 32'h2000);
        check("rst_shb", {18'd0, shadow_b_o}, 32'h2000);
        check("rst_psrdy", {31'd0, ps_ready_o}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Directed PS write to channel B.
        ps_pend = 1'b1; ps_s = 1'b1; ps_d = 14'h1234;
        run(6);
        check("dir_shb", {18'd0, shadow_b_o}, 32'h1234);
        check("dir_sha", {18'd0, shadow_a_o}, 32'h2000);

        // Servo request arrives while busy with a PS write; it must wait for IDLE.
        ps_pend = 1'b1; ps_s = 1'b1; ps_d = 14'h0555;
        step();
        lp_pend = 1'b1; lp_s = 1'b0; lp_d = 14'h3FFF;
        run(9);
        check("full_sha", {18'd0, shadow_a_o}, 32'h3FFF);

        // Both requesters continuously valid.
        ps_rate = 100; lp_rate = 100;
        lp_before = lp_accepts;
        run(40);
`ifndef DAC_ARB_ROUND_ROBIN_EN
        // Drop servo traffic; the waiting PS request gets served.
        lp_rate = 0;
        run(12);
`endif
        check("both_lp_served", {31'd0, (lp_accepts > lp_before)}, 32'd1);

        // Randomised mixed traffic, then drain.
        ps_rate = 40; lp_rate = 40;
        run(400);
        ps_rate = 0; lp_rate = 0;
        run(12);

        // Reset during STROBE.
        lp_pend = 1'b1; lp_s = 1'b1; lp_d = 14'h0ABC;
        guard = 0;
        while (busy_cnt != 2 && guard < 20) begin step(); guard++; end
        check("reach_strobe", {31'd0, (busy_cnt == 2)}, 32'd1);
        check("strobe_high", {31'd0, dac_wrt_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("async_wrt", {31'd0, dac_wrt_o}, 32'd0);
        check("async_dat", {18'd0, dac_dat_o}, 32'h2000);
        check("async_sel", {31'd0, dac_sel_o}, 32'd0);
        check("async_sha", {18'd0, shadow_a_o}, 32'h2000);
        check("async_shb", {18'd0, shadow_b_o}, 32'h2000);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Idle with no valids for 100 cycles: no extra strobe, pins unchanged.
        run(100);

        check("queue_empty", exp_q.size(), 32'd0);
        check("saw_strobes", {31'd0, (strobes > 20)}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
